dmem_arbiter: RTL and testbench

- Shares the single-port data memory (dmem: combinational read, one access per cycle) between two requesters: the CPU data port and a debug/DMA loader port.
- Translates byte addresses in the data segment into dmem word indices.
- Applies round-robin arbitration and runs a two-stage pipeline (accept -> memory access -> response).
- Sits between the cpu and dmem instances in the top-level computer.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_addr_map.sv | 29 ++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter and its address map.
package dmem_arb_pkg;

  // Requester identity; also the encoding of the round-robin pointer.
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

  // Byte address of dmem word 0 in the data segment.
  localparam logic [31:0] DMEM_BASE_DEF = 32'h1001_0000;

  // Width-independent part of a pipeline stage record. The top wraps this
  // with its parameter-sized idx/wdata fields to form the full record.
  typedef struct packed {
    logic    valid;
    req_id_t owner;
    logic    we;
    logic    fault;
  } stage_ctl_t;

endpackage

// File: rtl/dmem_addr_map.sv
// Byte address to memory word index translation with range/alignment fault.
// Purely combinational; BASE selects the segment (dmem or imem loader).
module dmem_addr_map #(
  parameter int unsigned ADDR_W = 11,
  parameter logic [31:0] BASE   = 32'h1001_0000
) (
  input  logic [31:0]       addr,
  output logic [ADDR_W-1:0] idx,
  output logic              fault
);

  logic [31:0] offset;
  logic [31:0] word_off;
  logic        below_base;
  logic        past_end;
  logic        misaligned;

  // Offset wraps on underflow; the underflow test uses the compare instead.
  always_comb begin
    offset     = addr - BASE;
    word_off   = offset >> 2;
    below_base = (addr < BASE);
    past_end   = ((word_off >> ADDR_W) != '0);
    misaligned = (addr[1:0] != 2'b00);
    idx        = word_off[ADDR_W-1:0];
    fault      = below_base | past_end | misaligned;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port dmem between the CPU data port
// and the debug/DMA loader port. Pipeline: accept -> memory access -> response.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // CPU data port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  // Debug / DMA loader port
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err,
  // dmem side
  output logic              mem_r,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Full stage record: package control fields plus parameter-sized payload.
  typedef struct packed {
    stage_ctl_t        ctl;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] wdata;
  } stage_t;

  req_id_t           rr_ptr;
  req_id_t           winner;
  logic              grant;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [ADDR_W-1:0] map_idx;
  logic              map_fault;
  stage_t            stage_a;
  logic              a_cpu;
  logic              a_dbg;

  // Winner selection: a lone requester wins; on a tie the pointer decides.
  always_comb begin
    winner = REQ_CPU;
    if (cpu_req && dbg_req) begin
      winner = rr_ptr;
    end else if (dbg_req) begin
      winner = REQ_DBG;
    end
  end

  // Grants are combinational and forced low while reset is held.
  always_comb begin
    cpu_gnt   = cpu_req & ~rst & (winner == REQ_CPU);
    dbg_gnt   = dbg_req & ~rst & (winner == REQ_DBG);
    grant     = cpu_gnt | dbg_gnt;
    sel_we    = (winner == REQ_DBG) ? dbg_we    : cpu_we;
    sel_addr  = (winner == REQ_DBG) ? dbg_addr  : cpu_addr;
    sel_wdata = (winner == REQ_DBG) ? dbg_wdata : cpu_wdata;
  end

  dmem_addr_map #(
    .ADDR_W (ADDR_W),
    .BASE   (DMEM_BASE)
  ) u_addr_map (
    .addr  (sel_addr),
    .idx   (map_idx),
    .fault (map_fault)
  );

  // Round-robin pointer: after a grant the other requester gets priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= REQ_CPU;
    end else if (grant) begin
      rr_ptr <= (winner == REQ_CPU) ? REQ_DBG : REQ_CPU;
    end
  end

  // Stage A register; payload only loads on a grant so mem_addr/mem_wdata
  // hold their last value while the pipeline is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_a <= '0;
    end else begin
      stage_a.ctl.valid <= grant;
      if (grant) begin
        stage_a.ctl.owner <= winner;
        stage_a.ctl.we    <= sel_we;
        stage_a.ctl.fault <= map_fault;
        stage_a.idx       <= map_idx;
        stage_a.wdata     <= sel_wdata;
      end
    end
  end

  // Stage B: drive dmem from the registered access; faults raise no strobe.
  always_comb begin
    mem_addr  = stage_a.idx;
    mem_wdata = stage_a.wdata;
    mem_w     = stage_a.ctl.valid &  stage_a.ctl.we & ~stage_a.ctl.fault;
    mem_r     = stage_a.ctl.valid & ~stage_a.ctl.we & ~stage_a.ctl.fault;
    a_cpu     = stage_a.ctl.valid & (stage_a.ctl.owner == REQ_CPU);
    a_dbg     = stage_a.ctl.valid & (stage_a.ctl.owner == REQ_DBG);
  end

  // Response registers: one-cycle done to the owner, read data only for good reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      dbg_done  <= 1'b0;
      dbg_err   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      cpu_done  <= a_cpu;
      cpu_err   <= a_cpu & stage_a.ctl.fault;
      cpu_rdata <= (a_cpu & mem_r) ? mem_rdata : '0;
      dbg_done  <= a_dbg;
      dbg_err   <= a_dbg & stage_a.ctl.fault;
      dbg_rdata <= (a_dbg & mem_r) ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a combinational-read dmem model.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we, cpu_gnt, cpu_done, cpu_err;
  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dbg_req, dbg_we, dbg_gnt, dbg_done, dbg_err;
  logic [31:0]       dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic              mem_r, mem_w;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic [DATA_W-1:0] mem [0:2047];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  dmem_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DMEM_BASE (32'h1001_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_done  (dbg_done),
    .dbg_rdata (dbg_rdata),
    .dbg_err   (dbg_err),
    .mem_r     (mem_r),
    .mem_w     (mem_w),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // dmem model: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_w) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One isolated access: grant in N, dmem strobe in N+1, response in N+2.
  task automatic single_access(input logic is_dbg, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic exp_strobe, input logic [31:0] exp_idx,
                               input logic exp_err, input logic [31:0] exp_rdata);
    tick();
    if (is_dbg) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    #1;
    check("own_gnt",   is_dbg ? dbg_gnt : cpu_gnt, 1);
    check("other_gnt", is_dbg ? cpu_gnt : dbg_gnt, 0);
    tick();
    idle();
    #1;
    check("mem_r", mem_r, exp_strobe & ~we);
    check("mem_w", mem_w, exp_strobe & we);
    if (exp_strobe) check("mem_addr", mem_addr, exp_idx);
    if (exp_strobe & we) check("mem_wdata", mem_wdata, wdata);
    check("early_done", is_dbg ? dbg_done : cpu_done, 0);
    tick();
    #1;
    check("own_done",   is_dbg ? dbg_done : cpu_done, 1);
    check("own_err",    is_dbg ? dbg_err : cpu_err, exp_err);
    check("own_rdata",  is_dbg ? dbg_rdata : cpu_rdata, exp_rdata);
    check("other_done", is_dbg ? cpu_done : dbg_done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end

  initial begin
    logic [5:0] exp_cg, exp_dg, exp_cd, exp_dd;
    for (int i = 0; i < 2048; i++) mem[i] = 32'hA000_0000 | i;
    idle();
    rst = 1'b1;
    tick();
    tick();
    // Reset state
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_dbg_gnt", dbg_gnt, 0);
    check("rst_cpu_done", cpu_done, 0);
    check("rst_dbg_done", dbg_done, 0);
    check("rst_cpu_err", cpu_err, 0);
    check("rst_dbg_err", dbg_err, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_mem_r", mem_r, 0);
    check("rst_mem_w", mem_w, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;

    // Write then read back through the CPU port
    single_access(1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 1'b1, 2, 1'b0, 32'h0);
    single_access(1'b0, 1'b0, 32'h1001_0008, 32'h0, 1'b1, 2, 1'b0, 32'hDEAD_BEEF);

    // Faults and the last valid word
    single_access(1'b0, 1'b0, 32'h1000_FFFC, 32'h0, 1'b0, 0, 1'b1, 32'h0);
    single_access(1'b1, 1'b0, 32'h1001_2000, 32'h0, 1'b0, 0, 1'b1, 32'h0);
    single_access(1'b0, 1'b0, 32'h1001_0006, 32'h0, 1'b0, 0, 1'b1, 32'h0);
    single_access(1'b1, 1'b0, 32'h1001_1FFC, 32'h0, 1'b1, 2047, 1'b0, 32'hA000_07FF);
    single_access(1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 0, 1'b1, 32'h0);
    check("fault_write_dropped", mem[0], 32'hA000_0000);

    // Round robin from reset: CPU, DBG, CPU, DBG
    do_reset();
    exp_cg = 6'b000101;
    exp_dg = 6'b001010;
    exp_cd = 6'b010100;
    exp_dd = 6'b101000;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c < 4) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0008;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h1001_0004;
      end else begin
        idle();
      end
      #1;
      check("rr_cpu_gnt", cpu_gnt, exp_cg[c]);
      check("rr_dbg_gnt", dbg_gnt, exp_dg[c]);
      check("rr_cpu_done", cpu_done, exp_cd[c]);
      check("rr_dbg_done", dbg_done, exp_dd[c]);
      if (exp_cd[c]) check("rr_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
      if (exp_dd[c]) check("rr_dbg_rdata", dbg_rdata, 32'hA000_0001);
    end

    // DBG write idx 5 in N, CPU read idx 5 in N+1
    tick();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h1001_0014; dbg_wdata = 32'h11;
    #1;
    check("raw_dbg_gnt", dbg_gnt, 1);
    tick();
    idle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0014;
    #1;
    check("raw_cpu_gnt", cpu_gnt, 1);
    check("raw_mem_w", mem_w, 1);
    check("raw_mem_addr_w", mem_addr, 5);
    tick();
    idle();
    #1;
    check("raw_dbg_done", dbg_done, 1);
    check("raw_mem_r", mem_r, 1);
    check("raw_mem_addr_r", mem_addr, 5);
    tick();
    #1;
    check("raw_cpu_done", cpu_done, 1);
    check("raw_cpu_rdata", cpu_rdata, 32'h11);
    check("raw_dbg_done_idle", dbg_done, 0);

    // Reset in the cycle after a grant
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1001_0010; cpu_wdata = 32'h55;
    #1;
    check("mid_cpu_gnt", cpu_gnt, 1);
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0008;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h1001_0004;
    rst = 1'b1;
    #1;
    check("mid_rst_mem_w", mem_w, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_cpu_gnt", cpu_gnt, 0);
    check("mid_rst_dbg_gnt", dbg_gnt, 0);
    check("mid_rst_cpu_done", cpu_done, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_cpu_gnt", cpu_gnt, 1);
    check("post_rst_dbg_gnt", dbg_gnt, 0);
    check("post_rst_cpu_done", cpu_done, 0);
    check("post_rst_dbg_done", dbg_done, 0);
    tick();
    idle();
    #1;
    check("post_rst_mem_r", mem_r, 1);
    check("post_rst_no_done", cpu_done, 0);
    tick();
    #1;
    check("post_rst_cpu_done2", cpu_done, 1);
    check("post_rst_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("post_rst_dbg_done2", dbg_done, 0);
    check("dropped_write", mem[4], 32'hA000_0004);

    // DBG streaming reads, 8 back-to-back
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c < 8) begin
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h1001_0020 + 32'(4 * c);
      end else begin
        idle();
      end
      #1;
      check("stream_gnt", dbg_gnt, (c < 8) ? 1 : 0);
      check("stream_done", dbg_done, (c >= 2) ? 1 : 0);
      if (c >= 2) check("stream_rdata", dbg_rdata, 32'hA000_0000 | 32'(8 + c - 2));
      check("stream_cpu_done", cpu_done, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
